// File: rtl/bsg_imul_iterative_shift_add.sv
// Purpose : iterative shift-add integer multiplier, signed/unsigned per operand,
//           returns the low or high half of the 2*width_p product.
// Latency : width_p/bits_per_iter_p CALC cycles + 1 ADJ cycle; v_o rises on the
//           (N+2)th edge counting the accept edge as the first.
// Backpres: result_o/v_o held in DONE until yumi_i; no new accept until then.
//
// Ports:
//   clk_i, reset_i            clock, synchronous active-high reset
//   v_i / ready_and_o         request handshake (accept on v_i & ready_and_o)
//   opA_i, opB_i              multiplicand / multiplier
//   signed_opA_i/signed_opB_i per-operand two's-complement select
//   gets_high_part_i          1 = upper half of product, 0 = lower half
//   result_o / v_o / yumi_i   response handshake
//
// bits_per_iter_p must be 1, 2 or 4 and divide width_p.
module bsg_imul_iterative_shift_add #(
   parameter int width_p         = 32,
   parameter int bits_per_iter_p = 1
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               v_i,
   output logic               ready_and_o,
   input  logic [width_p-1:0] opA_i,
   input  logic [width_p-1:0] opB_i,
   input  logic               signed_opA_i,
   input  logic               signed_opB_i,
   input  logic               gets_high_part_i,
   output logic [width_p-1:0] result_o,
   output logic               v_o,
   input  logic               yumi_i
);

   localparam int iter_lp  = width_p / bits_per_iter_p;
   localparam int cnt_w_lp = $clog2(iter_lp + 1);
   localparam int dw_lp    = 2 * width_p;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      ADJ  = 2'd2,
      DONE = 2'd3
   } state_e;

   state_e r_state;
   state_e w_state_nxt;

   logic [dw_lp-1:0]    r_a;       // |A|, shifted left by bits_per_iter_p each CALC cycle
   logic [width_p-1:0]  r_b;       // |B|, shifted right; low digit feeds the partial product
   logic [dw_lp-1:0]    r_acc;
   logic [cnt_w_lp-1:0] r_cnt;
   logic                r_neg;
   logic                r_high;
   logic [width_p-1:0]  r_result;

   logic                       w_accept;
   logic                       w_a_neg;
   logic                       w_b_neg;
   logic [width_p-1:0]         w_a_mag;
   logic [width_p-1:0]         w_b_mag;
   logic [bits_per_iter_p-1:0] w_digit;
   logic [dw_lp-1:0]           w_pp;
   logic [dw_lp-1:0]           w_acc_sum;
   logic [dw_lp-1:0]           w_acc_adj;
   logic                       w_last_iter;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk_i) begin
      if (reset_i) r_state <= IDLE;
      else         r_state <= w_state_nxt;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_accept)    w_state_nxt = CALC;
         CALC:    if (w_last_iter) w_state_nxt = ADJ;
         ADJ:                      w_state_nxt = DONE;
         DONE:    if (yumi_i)      w_state_nxt = IDLE;
         default:                  w_state_nxt = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      ready_and_o = (r_state == IDLE) & ~reset_i;
      v_o         = (r_state == DONE);
      result_o    = r_result;
   end

   // ---------------- datapath ----------------
   assign w_accept = v_i & ready_and_o;

   // Signed operands with MSB set become their magnitude; the most negative
   // value maps to 2^(width_p-1), which still fits as unsigned width_p bits.
   assign w_a_neg = signed_opA_i & opA_i[width_p-1];
   assign w_b_neg = signed_opB_i & opB_i[width_p-1];
   assign w_a_mag = w_a_neg ? -opA_i : opA_i;
   assign w_b_mag = w_b_neg ? -opB_i : opB_i;

   // Multiplicand is pre-shifted, so each cycle adds |A|<<shift times one digit.
   assign w_digit     = r_b[bits_per_iter_p-1:0];
   assign w_pp        = r_a * {{(dw_lp-bits_per_iter_p){1'b0}}, w_digit};
   assign w_acc_sum   = r_acc + w_pp;
   assign w_acc_adj   = r_neg ? -r_acc : r_acc;
   assign w_last_iter = (r_cnt == cnt_w_lp'(1));

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_a      <= '0;
         r_b      <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_neg    <= 1'b0;
         r_high   <= 1'b0;
         r_result <= '0;
      end else if (w_accept) begin
         r_a      <= {{width_p{1'b0}}, w_a_mag};
         r_b      <= w_b_mag;
         r_acc    <= '0;
         r_cnt    <= cnt_w_lp'(iter_lp);
         r_neg    <= w_a_neg ^ w_b_neg;
         r_high   <= gets_high_part_i;
      end else if (r_state == CALC) begin
         r_acc    <= w_acc_sum;
         r_a      <= r_a << bits_per_iter_p;
         r_b      <= r_b >> bits_per_iter_p;
         r_cnt    <= r_cnt - cnt_w_lp'(1);
      end else if (r_state == ADJ) begin
         r_result <= r_high ? w_acc_adj[dw_lp-1:width_p] : w_acc_adj[width_p-1:0];
      end
   end

   // Taking a result that is not being offered is a caller bug.
   a_yumi_only_when_valid: assert property (
      @(posedge clk_i) disable iff (reset_i) yumi_i |-> v_o
   );

endmodule

// File: tb/tb_bsg_imul_iterative_shift_add.sv
module tb_bsg_imul_iterative_shift_add;

   localparam int W   = 32;
   localparam int BPI = 2;
   localparam int N   = W / BPI;

   logic          clk_i = 1'b0;
   logic          reset_i;
   logic          v_i;
   logic          ready_and_o;
   logic [W-1:0]  opA_i;
   logic [W-1:0]  opB_i;
   logic          signed_opA_i;
   logic          signed_opB_i;
   logic          gets_high_part_i;
   logic [W-1:0]  result_o;
   logic          v_o;
   logic          yumi_i;

   int n_checks = 0;
   int n_pass   = 0;

   bsg_imul_iterative_shift_add #(
      .width_p         (W),
      .bits_per_iter_p (BPI)
   ) dut (
      .clk_i            (clk_i),
      .reset_i          (reset_i),
      .v_i              (v_i),
      .ready_and_o      (ready_and_o),
      .opA_i            (opA_i),
      .opB_i            (opB_i),
      .signed_opA_i     (signed_opA_i),
      .signed_opB_i     (signed_opB_i),
      .gets_high_part_i (gets_high_part_i),
      .result_o         (result_o),
      .v_o              (v_o),
      .yumi_i           (yumi_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
   endtask

   function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                           input logic sa, input logic sb);
      logic [63:0] a64;
      logic [63:0] b64;
      a64 = sa ? {{32{a[31]}}, a} : {32'h0, a};
      b64 = sb ? {{32{b[31]}}, b} : {32'h0, b};
      return a64 * b64;
   endfunction

   // Issues one request and waits for v_o. idx is the index of the edge on
   // which v_o rose, counting the accept edge as edge 1. Called at a negedge;
   // returns at a negedge.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sa,
                         input logic sb, input logic hi,
                         output logic [31:0] res, output int idx);
      int k;
      k = 0;
      while (!ready_and_o && k < 100) begin
         @(negedge clk_i);
         k++;
      end
      if (!ready_and_o) check("ready_timeout", 64'd0, 64'd1);
      v_i = 1'b1; opA_i = a; opB_i = b;
      signed_opA_i = sa; signed_opB_i = sb; gets_high_part_i = hi;
      @(posedge clk_i);
      @(negedge clk_i);
      v_i = 1'b0;
      // Operands after the accept edge must be ignored.
      opA_i = $urandom; opB_i = $urandom;
      signed_opA_i = ~sa; signed_opB_i = ~sb; gets_high_part_i = ~hi;
      idx = 1;
      k = 0;
      while (!v_o && k < 200) begin
         @(posedge clk_i);
         idx++;
         @(negedge clk_i);
         k++;
      end
      if (!v_o) check("v_o_timeout", 64'd0, 64'd1);
      res = result_o;
   endtask

   // Consume the pending result; ready must return on the next cycle.
   task automatic take_result(input string tag);
      yumi_i = 1'b1;
      @(negedge clk_i);
      yumi_i = 1'b0;
      check({tag, "_ready_after_yumi"}, 64'(ready_and_o), 64'd1);
      check({tag, "_v_o_after_yumi"}, 64'(v_o), 64'd0);
   endtask

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        sa;
      logic        sb;
      logic        hi;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[11];

   initial begin
      logic [31:0] res;
      logic [31:0] held;
      logic [63:0] prod;
      int          idx;
      int          stray_v;
      vec_t        rv;

      vecs[0]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 32'h00000001};
      vecs[1]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFE};
      vecs[2]  = '{32'hFFFFFFFD, 32'h00000007, 1'b1, 1'b1, 1'b0, 32'hFFFFFFEB};
      vecs[3]  = '{32'hFFFFFFFD, 32'h00000007, 1'b1, 1'b1, 1'b1, 32'hFFFFFFFF};
      vecs[4]  = '{32'h80000000, 32'h80000000, 1'b1, 1'b1, 1'b1, 32'h40000000};
      vecs[5]  = '{32'h80000000, 32'h80000000, 1'b1, 1'b1, 1'b0, 32'h00000000};
      vecs[6]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 32'hFFFFFFFF};
      vecs[7]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 32'h00000001};
      vecs[8]  = '{32'h00000000, 32'hFFFFFFFB, 1'b0, 1'b1, 1'b1, 32'h00000000};
      vecs[9]  = '{32'h00000000, 32'hFFFFFFFB, 1'b0, 1'b1, 1'b0, 32'h00000000};
      // 0xFFFFFFFD * 7 unsigned = 0x6_FFFFFFEB: same low half as the signed case.
      vecs[10] = '{32'hFFFFFFFD, 32'h00000007, 1'b0, 1'b0, 1'b1, 32'h00000006};

      reset_i = 1'b1; v_i = 1'b0; yumi_i = 1'b0;
      opA_i = '0; opB_i = '0;
      signed_opA_i = 1'b0; signed_opB_i = 1'b0; gets_high_part_i = 1'b0;

      // ---- reset state ----
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      check("rst_ready", 64'(ready_and_o), 64'd0);
      check("rst_v_o", 64'(v_o), 64'd0);
      check("rst_result", 64'(result_o), 64'd0);
      reset_i = 1'b0;
      #1;
      check("rst_release_ready", 64'(ready_and_o), 64'd1);
      @(negedge clk_i);

      // ---- directed vectors ----
      foreach (vecs[i]) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].sa, vecs[i].sb, vecs[i].hi, res, idx);
         check($sformatf("vec%0d_result", i), 64'(res), 64'(vecs[i].exp));
         check($sformatf("vec%0d_latency", i), 64'(idx), 64'(N + 2));
         take_result($sformatf("vec%0d", i));
      end

      // ---- backpressure: hold yumi low for 5 cycles ----
      run_op(32'd1000, 32'd1000, 1'b0, 1'b0, 1'b0, held, idx);
      check("bp_result", 64'(held), 64'd1000000);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk_i);
         check($sformatf("bp_v_o_c%0d", c), 64'(v_o), 64'd1);
         check($sformatf("bp_hold_c%0d", c), 64'(result_o), 64'(held));
         check($sformatf("bp_ready_c%0d", c), 64'(ready_and_o), 64'd0);
      end
      take_result("bp");

      // ---- reset during the 5th CALC cycle ----
      v_i = 1'b1; opA_i = 32'd123; opB_i = 32'd456;
      signed_opA_i = 1'b0; signed_opB_i = 1'b0; gets_high_part_i = 1'b0;
      @(posedge clk_i);
      @(negedge clk_i);            // 1st CALC cycle
      v_i = 1'b0;
      repeat (4) @(negedge clk_i); // 5th CALC cycle
      reset_i = 1'b1;
      @(negedge clk_i);
      check("midrst_ready_in_reset", 64'(ready_and_o), 64'd0);
      reset_i = 1'b0;
      #1;
      check("midrst_ready_after", 64'(ready_and_o), 64'd1);
      stray_v = 0;
      for (int c = 0; c < N + 10; c++) begin
         @(negedge clk_i);
         if (v_o) stray_v++;
      end
      check("midrst_no_v_o", 64'(stray_v), 64'd0);
      run_op(32'd6, 32'd7, 1'b0, 1'b0, 1'b0, res, idx);
      check("midrst_next_op", 64'(res), 64'd42);
      take_result("midrst");

      // ---- random regression against a 64-bit reference ----
      for (int r = 0; r < 300; r++) begin
         rv.a  = $urandom;
         rv.b  = $urandom;
         if (r % 8 == 0) rv.a = 32'h80000000;
         if (r % 11 == 0) rv.b = 32'h0;
         rv.sa = 1'($urandom_range(0, 1));
         rv.sb = 1'($urandom_range(0, 1));
         rv.hi = 1'($urandom_range(0, 1));
         prod  = ref_mul(rv.a, rv.b, rv.sa, rv.sb);
         run_op(rv.a, rv.b, rv.sa, rv.sb, rv.hi, res, idx);
         check($sformatf("rand%0d_a%h_b%h_s%0d%0d_h%0d", r, rv.a, rv.b, rv.sa, rv.sb, rv.hi),
               64'(res), rv.hi ? 64'(prod[63:32]) : 64'(prod[31:0]));
         take_result($sformatf("rand%0d", r));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
